div_sequencer: RTL

Control FSM for the divide-by-repeated-subtraction datapath. It steps the 3-bit `selector` of the microcode memory through CLR → LD1 → LD2 → LD3 → DIV… → RES → DIS, and strobes `step_en` so the datapath applies each decoded func/value. It waits on the datapath's `div_done`, optionally watches for a hung divide, and reports `busy`, `done` and `error` to the top level.

---
 rtl/div_sequencer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/div_sequencer.sv
// Sequencer for the repeated-subtraction divider: walks the microcode selector
// and strobes step_en. Optional DIV watchdog enabled by DIV_SEQ_WATCHDOG_EN.
module div_sequencer #(
   parameter int DIV_TIMEOUT = 16,
   parameter int DIS_HOLD    = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       start_i,
   input  logic       div_done_i,
   output logic [2:0] selector_o,
   output logic       step_en_o,
   output logic       busy_o,
   output logic       done_o,
   output logic       error_o
);

   // state | meaning
   // IDLE  | waiting for start, selector holds last code
   // CLR   | clear datapath registers (1 cycle)
   // LD1   | load step 1 (1 cycle)
   // LD2   | load step 2 (1 cycle)
   // LD3   | load step 3 (1 cycle)
   // DIV   | repeated subtraction until div_done (or watchdog)
   // RES   | latch result (1 cycle)
   // DIS   | display result for DIS_HOLD cycles
   // ERR   | divide timed out, error sticky until next start
   typedef enum logic [3:0] {
      S_IDLE, S_CLR, S_LD1, S_LD2, S_LD3, S_DIV, S_RES, S_DIS, S_ERR
   } state_t;

   localparam logic [2:0] SEL_CLR = 3'b000;
   localparam logic [2:0] SEL_LD1 = 3'b001;
   localparam logic [2:0] SEL_LD2 = 3'b010;
   localparam logic [2:0] SEL_LD3 = 3'b011;
   localparam logic [2:0] SEL_DIV = 3'b100;
   localparam logic [2:0] SEL_RES = 3'b101;
   localparam logic [2:0] SEL_DIS = 3'b110;

   localparam int CNT_MAX = (DIV_TIMEOUT > DIS_HOLD) ? DIV_TIMEOUT : DIS_HOLD;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] DIS_LAST = CNT_W'(DIS_HOLD - 1);
`ifdef DIV_SEQ_WATCHDOG_EN
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(DIV_TIMEOUT - 1);
   logic             err_q;
`endif

   state_t           state_q;
   logic [2:0]       sel_q;
   logic             step_q;
   logic             busy_q;
   logic             done_q;
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         sel_q   <= SEL_CLR;
         step_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
`ifdef DIV_SEQ_WATCHDOG_EN
         err_q   <= 1'b0;
`endif
      end else begin
         // step_en and done are strobes; each transition below re-asserts as needed
         step_q <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  state_q <= S_CLR;
                  sel_q   <= SEL_CLR;
                  step_q  <= 1'b1;
                  busy_q  <= 1'b1;
                  cnt_q   <= '0;
               end
            end
            S_CLR: begin
               state_q <= S_LD1;
               sel_q   <= SEL_LD1;
               step_q  <= 1'b1;
               cnt_q   <= '0;
            end
            S_LD1: begin
               state_q <= S_LD2;
               sel_q   <= SEL_LD2;
               step_q  <= 1'b1;
               cnt_q   <= '0;
            end
            S_LD2: begin
               state_q <= S_LD3;
               sel_q   <= SEL_LD3;
               step_q  <= 1'b1;
               cnt_q   <= '0;
            end
            S_LD3: begin
               state_q <= S_DIV;
               sel_q   <= SEL_DIV;
               step_q  <= 1'b1;
               cnt_q   <= '0;
            end
            S_DIV: begin
               // div_done takes priority over a timeout on the same cycle
               if (div_done_i) begin
                  state_q <= S_RES;
                  sel_q   <= SEL_RES;
                  step_q  <= 1'b1;
                  cnt_q   <= '0;
               end
`ifdef DIV_SEQ_WATCHDOG_EN
               else if (cnt_q == TMO_LAST) begin
                  state_q <= S_ERR;
                  sel_q   <= SEL_CLR;
                  busy_q  <= 1'b0;
                  err_q   <= 1'b1;
                  cnt_q   <= '0;
               end else begin
                  step_q  <= 1'b1;
                  cnt_q   <= cnt_q + CNT_W'(1);
               end
`else
               else begin
                  step_q  <= 1'b1;
               end
`endif
            end
            S_RES: begin
               state_q <= S_DIS;
               sel_q   <= SEL_DIS;
               step_q  <= 1'b1;
               cnt_q   <= '0;
            end
            S_DIS: begin
               if (cnt_q == DIS_LAST) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  cnt_q   <= '0;
               end else begin
                  cnt_q   <= cnt_q + CNT_W'(1);
               end
            end
            S_ERR: begin
               if (start_i) begin
                  state_q <= S_CLR;
                  sel_q   <= SEL_CLR;
                  step_q  <= 1'b1;
                  busy_q  <= 1'b1;
                  cnt_q   <= '0;
`ifdef DIV_SEQ_WATCHDOG_EN
                  err_q   <= 1'b0;
`endif
               end
            end
            default: begin
               state_q <= S_IDLE;
               sel_q   <= SEL_CLR;
               busy_q  <= 1'b0;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign selector_o = sel_q;
   assign step_en_o  = step_q;
   assign busy_o     = busy_q;
   assign done_o     = done_q;
`ifdef DIV_SEQ_WATCHDOG_EN
   assign error_o    = err_q;
`else
   assign error_o    = 1'b0;
`endif

endmodule
